// File: rtl/fu_scheduler.sv
// Round-robin scheduler that shares one combinational function unit between two decode lanes.
// It registers the granted operation into the unit, captures the result, and holds it until the consumer accepts it.
module fu_scheduler #(
  parameter int TAGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [6:0]      req_opcode0,
  input  logic [31:0]     req_a0,
  input  logic [31:0]     req_b0,
  input  logic [4:0]      req_sh0,
  input  logic [TAGW-1:0] req_tag0,
  input  logic [6:0]      req_opcode1,
  input  logic [31:0]     req_a1,
  input  logic [31:0]     req_b1,
  input  logic [4:0]      req_sh1,
  input  logic [TAGW-1:0] req_tag1,
  output logic [6:0]      fu_opcode,
  output logic [31:0]     fu_a,
  output logic [31:0]     fu_b,
  output logic [4:0]      fu_sh,
  output logic [3:0]      fu_fs,
  input  logic [31:0]     fu_fout,
  input  logic            fu_carryout,
  input  logic            fu_overflow,
  input  logic            fu_negative,
  input  logic            fu_zero,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [TAGW-1:0] resp_tag,
  output logic [31:0]     resp_result,
  output logic [3:0]      resp_flags,
  output logic [CNTW-1:0] op_count
);

  // Handshake rule on both sides: a transfer happens on a rising edge where
  // valid and ready are both high; the sender holds valid and payload until then.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [6:0]      fu_opcode_q, fu_opcode_d;
  logic [31:0]     fu_a_q, fu_a_d;
  logic [31:0]     fu_b_q, fu_b_d;
  logic [4:0]      fu_sh_q, fu_sh_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_id_q, resp_id_d;
  logic [TAGW-1:0] resp_tag_q, resp_tag_d;
  logic [31:0]     resp_result_q, resp_result_d;
  logic [3:0]      resp_flags_q, resp_flags_d;
  logic [CNTW-1:0] op_count_q, op_count_d;

  logic            grant_idx;
  logic            accept;

  // When both lanes ask, the lane that did not win last time goes first.
  always_comb begin
    grant_idx = 1'b0;
    req_ready = 2'b00;
    if (&req_valid) begin
      grant_idx = ~last_grant_q;
    end else begin
      grant_idx = req_valid[1];
    end
    if (state_q == IDLE && |req_valid) begin
      req_ready = grant_idx ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    fu_opcode_d   = fu_opcode_q;
    fu_a_d        = fu_a_q;
    fu_b_d        = fu_b_q;
    fu_sh_d       = fu_sh_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_tag_d    = resp_tag_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    op_count_d    = op_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          fu_opcode_d  = grant_idx ? req_opcode1 : req_opcode0;
          fu_a_d       = grant_idx ? req_a1 : req_a0;
          fu_b_d       = grant_idx ? req_b1 : req_b0;
          fu_sh_d      = grant_idx ? req_sh1 : req_sh0;
          resp_tag_d   = grant_idx ? req_tag1 : req_tag0;
          resp_id_d    = grant_idx;
          last_grant_d = grant_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        resp_result_d = fu_fout;
        resp_flags_d  = {fu_carryout, fu_overflow, fu_negative, fu_zero};
        resp_valid_d  = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          op_count_d   = op_count_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      fu_opcode_q   <= '0;
      fu_a_q        <= '0;
      fu_b_q        <= '0;
      fu_sh_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_tag_q    <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      fu_opcode_q   <= fu_opcode_d;
      fu_a_q        <= fu_a_d;
      fu_b_q        <= fu_b_d;
      fu_sh_q       <= fu_sh_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_tag_q    <= resp_tag_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      op_count_q    <= op_count_d;
    end
  end

  assign fu_opcode   = fu_opcode_q;
  assign fu_a        = fu_a_q;
  assign fu_b        = fu_b_q;
  assign fu_sh       = fu_sh_q;
  assign fu_fs       = 4'b0000;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_tag    = resp_tag_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_fu_scheduler.sv
// Directed bench for fu_scheduler with a small ADD/SUB function-unit model on the fu_* ports.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fu_scheduler;

  localparam int TAGW = 5;
  localparam int CNTW = 4;
  localparam logic [6:0] OP_ADD = 7'h10;
  localparam logic [6:0] OP_SUB = 7'h11;

  logic            clk;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [6:0]      req_opcode0, req_opcode1;
  logic [31:0]     req_a0, req_b0, req_a1, req_b1;
  logic [4:0]      req_sh0, req_sh1;
  logic [TAGW-1:0] req_tag0, req_tag1;
  logic [6:0]      fu_opcode;
  logic [31:0]     fu_a, fu_b;
  logic [4:0]      fu_sh;
  logic [3:0]      fu_fs;
  logic [31:0]     fu_fout;
  logic            fu_carryout, fu_overflow, fu_negative, fu_zero;
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_id;
  logic [TAGW-1:0] resp_tag;
  logic [31:0]     resp_result;
  logic [3:0]      resp_flags;
  logic [CNTW-1:0] op_count;

  int total;
  int bad;
  int cyc;
  logic [31:0] exp_q[$];
  logic [0:0]  exp_id_q[$];

  fu_scheduler #(.TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode0(req_opcode0), .req_a0(req_a0), .req_b0(req_b0),
    .req_sh0(req_sh0), .req_tag0(req_tag0),
    .req_opcode1(req_opcode1), .req_a1(req_a1), .req_b1(req_b1),
    .req_sh1(req_sh1), .req_tag1(req_tag1),
    .fu_opcode(fu_opcode), .fu_a(fu_a), .fu_b(fu_b), .fu_sh(fu_sh), .fu_fs(fu_fs),
    .fu_fout(fu_fout), .fu_carryout(fu_carryout), .fu_overflow(fu_overflow),
    .fu_negative(fu_negative), .fu_zero(fu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_tag(resp_tag), .resp_result(resp_result), .resp_flags(resp_flags),
    .op_count(op_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // function-unit model: carry is bit 32 of the extended add (a + ~b + 1 for SUB)
  logic [32:0] fu_ext;
  always_comb begin
    fu_ext      = {1'b0, fu_a};
    fu_overflow = 1'b0;
    if (fu_opcode == OP_ADD) begin
      fu_ext      = {1'b0, fu_a} + {1'b0, fu_b};
      fu_overflow = (fu_a[31] == fu_b[31]) && (fu_ext[31] != fu_a[31]);
    end else if (fu_opcode == OP_SUB) begin
      fu_ext      = {1'b0, fu_a} + {1'b0, ~fu_b} + 33'd1;
      fu_overflow = (fu_a[31] != fu_b[31]) && (fu_ext[31] != fu_a[31]);
    end
    fu_fout     = fu_ext[31:0];
    fu_carryout = fu_ext[32];
    fu_negative = fu_ext[31];
    fu_zero     = (fu_ext[31:0] == 32'd0);
  end

  // driver tasks
  task automatic do_reset();
    req_valid = 2'b00;
    resp_ready = 1'b0;
    req_opcode0 = '0; req_a0 = '0; req_b0 = '0; req_sh0 = '0; req_tag0 = '0;
    req_opcode1 = '0; req_a1 = '0; req_b1 = '0; req_sh1 = '0; req_tag1 = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one request and returns at the falling edge after it was accepted.
  task automatic issue(input int idx, input logic [6:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input logic [TAGW-1:0] tag, output bit ok);
    ok = 1'b0;
    if (idx == 0) begin
      req_opcode0 = op; req_a0 = a; req_b0 = b; req_sh0 = sh; req_tag0 = tag;
    end else begin
      req_opcode1 = op; req_a1 = a; req_b1 = b; req_sh1 = sh; req_tag1 = tag;
    end
    req_valid[idx] = 1'b1;
    #1;
    for (int t = 0; t < 20; t++) begin
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(negedge clk);
    end
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // tests
  task automatic test_reset();
    req_valid = 2'b00;
    resp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({resp_valid, resp_id, resp_tag, resp_result, resp_flags} !== '0) begin
      bad++; $display("FAIL reset_resp: got valid=%0b id=%0b tag=%0d res=%0h flags=%b, want all 0",
                      resp_valid, resp_id, resp_tag, resp_result, resp_flags);
    end
    total++;
    if ({fu_opcode, fu_a, fu_b, fu_sh, fu_fs} !== '0 || op_count !== '0) begin
      bad++; $display("FAIL reset_fu: got op=%0h a=%0h b=%0h sh=%0d fs=%0h cnt=%0d, want 0",
                      fu_opcode, fu_a, fu_b, fu_sh, fu_fs, op_count);
    end
    total++;
    if (req_ready !== 2'b00) begin
      bad++; $display("FAIL reset_ready_idle: got %b want 00", req_ready);
    end
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL reset_first_grant: got %b want 01", req_ready);
    end
    req_valid = 2'b10;
    #1;
    total++;
    if (req_ready !== 2'b10) begin
      bad++; $display("FAIL single_req1_grant: got %b want 10", req_ready);
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    bit ok;
    do_reset();
    resp_ready = 1'b1;
    issue(0, OP_ADD, 32'd5, 32'd3, 5'd2, 5'd7, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL add_accept: got no accept want accept within 20 cycles");
    end
    total++;
    if (fu_opcode !== OP_ADD || fu_a !== 32'd5 || fu_b !== 32'd3 || fu_sh !== 5'd2 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL add_fu_regs: got op=%0h a=%0d b=%0d sh=%0d rv=%0b want 10/5/3/2/0",
                      fu_opcode, fu_a, fu_b, fu_sh, resp_valid);
    end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b1 || resp_result !== 32'd8 || resp_id !== 1'b0 ||
        resp_tag !== 5'd7 || resp_flags !== 4'b0000 || req_ready !== 2'b00) begin
      bad++; $display("FAIL add_resp: got v=%0b res=%0d id=%0b tag=%0d flags=%b rdy=%b want 1/8/0/7/0000/00",
                      resp_valid, resp_result, resp_id, resp_tag, resp_flags, req_ready);
    end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || op_count !== 4'd1) begin
      bad++; $display("FAIL add_count: got v=%0b cnt=%0d want 0/1", resp_valid, op_count);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_contention();
    int last_cyc;
    logic g;
    logic [1:0] exp_rdy;
    logic [31:0] exp_res;
    logic [0:0] exp_id;
    bit found;
    do_reset();
    resp_ready = 1'b1;
    req_opcode0 = OP_ADD; req_a0 = 32'd10; req_b0 = 32'd1; req_tag0 = 5'd0;
    req_opcode1 = OP_SUB; req_a1 = 32'd100; req_b1 = 32'd1; req_tag1 = 5'd16;
    req_valid = 2'b11;
    last_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      found = 1'b0;
      #1;
      for (int t = 0; t < 10; t++) begin
        if (req_ready != 2'b00) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
        #1;
      end
      total++;
      if (!found) begin
        bad++; $display("FAIL contention_timeout: got no grant want grant for op %0d", i);
        break;
      end
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (req_ready !== exp_rdy) begin
        bad++; $display("FAIL contention_order: op %0d got %b want %b", i, req_ready, exp_rdy);
      end
      if (i > 0) begin
        total++;
        if (cyc - last_cyc != 3) begin
          bad++; $display("FAIL contention_rate: op %0d got %0d cycles want 3", i, cyc - last_cyc);
        end
      end
      last_cyc = cyc;
      g = req_ready[1];
      exp_id_q.push_back(g);
      exp_q.push_back(g ? (req_a1 - req_b1) : (req_a0 + req_b0));
      @(negedge clk);
      if (g) begin
        req_b1 = req_b1 + 32'd1;
      end else begin
        req_a0 = req_a0 + 32'd10;
      end
      @(negedge clk);
      exp_res = exp_q.pop_front();
      exp_id = exp_id_q.pop_front();
      total++;
      if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_result !== exp_res) begin
        bad++; $display("FAIL contention_resp: op %0d got v=%0b id=%0b res=%0d want 1/%0b/%0d",
                        i, resp_valid, resp_id, resp_result, exp_id, exp_res);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    total++;
    if (op_count !== 4'd8) begin
      bad++; $display("FAIL contention_count: got %0d want 8", op_count);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    issue(1, OP_ADD, 32'd20, 32'd22, 5'd0, 5'd3, ok);
    wait_resp(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL bp_resp_timeout: got no resp_valid want resp_valid");
    end
    req_opcode0 = OP_ADD; req_a0 = 32'hAB; req_b0 = 32'd1; req_tag0 = 5'd4;
    req_valid[0] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      total++;
      if (resp_valid !== 1'b1 || resp_result !== 32'd42 || resp_id !== 1'b1 ||
          resp_tag !== 5'd3 || req_ready !== 2'b00 || op_count !== 4'd0) begin
        bad++; $display("FAIL bp_hold: cycle %0d got v=%0b res=%0d id=%0b tag=%0d rdy=%b cnt=%0d want 1/42/1/3/00/0",
                        j, resp_valid, resp_result, resp_id, resp_tag, req_ready, op_count);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b0 || op_count !== 4'd1 || req_ready !== 2'b01 || fu_a !== 32'd20) begin
      bad++; $display("FAIL bp_release: got v=%0b cnt=%0d rdy=%b fu_a=%0h want 0/1/01/14",
                      resp_valid, op_count, req_ready, fu_a);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    total++;
    if (fu_a !== 32'hAB || req_ready !== 2'b00) begin
      bad++; $display("FAIL bp_next_accept: got fu_a=%0h rdy=%b want ab/00", fu_a, req_ready);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (op_count !== 4'd2) begin
      bad++; $display("FAIL bp_count: got %0d want 2", op_count);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_flags();
    bit ok;
    do_reset();
    issue(1, OP_SUB, 32'd3, 32'd3, 5'd0, 5'd9, ok);
    wait_resp(ok);
    total++;
    if (!ok || resp_result !== 32'd0 || resp_flags !== 4'b1001 || resp_id !== 1'b1 || resp_tag !== 5'd9) begin
      bad++; $display("FAIL flags_sub: got ok=%0b res=%0d flags=%b id=%0b tag=%0d want 1/0/1001/1/9",
                      ok, resp_result, resp_flags, resp_id, resp_tag);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    bit seen;
    do_reset();
    resp_ready = 1'b1;
    issue(0, OP_ADD, 32'd1, 32'd1, 5'd0, 5'd1, ok);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (op_count !== 4'd1) begin
      bad++; $display("FAIL midrst_pre_count: got %0d want 1", op_count);
    end
    issue(1, OP_ADD, 32'd7, 32'd7, 5'd0, 5'd2, ok);
    rst = 1'b1;
    #1;
    total++;
    if (resp_valid !== 1'b0 || op_count !== 4'd0 || fu_a !== 32'd0) begin
      bad++; $display("FAIL midrst_clear: got v=%0b cnt=%0d fu_a=%0d want 0/0/0", resp_valid, op_count, fu_a);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    total++;
    if (seen || op_count !== 4'd0) begin
      bad++; $display("FAIL midrst_no_resp: got seen=%0b cnt=%0d want 0/0", seen, op_count);
    end
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL midrst_grant: got %b want 01", req_ready);
    end
    req_valid = 2'b00;
    resp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_counter_wrap();
    bit ok;
    bit all_ok;
    do_reset();
    resp_ready = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      issue(i % 2, OP_ADD, i, 32'd1, 5'd0, 5'(i), ok);
      if (!ok) all_ok = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    total++;
    if (!all_ok || op_count !== 4'd15) begin
      bad++; $display("FAIL wrap_preload: got ok=%0b cnt=%0d want 1/15", all_ok, op_count);
    end
    issue(0, OP_ADD, 32'd2, 32'd2, 5'd0, 5'd0, ok);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (!ok || op_count !== 4'd0) begin
      bad++; $display("FAIL wrap_zero: got ok=%0b cnt=%0d want 1/0", ok, op_count);
    end
    resp_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    rst = 1'b1;
    req_valid = 2'b00;
    resp_ready = 1'b0;
    req_opcode0 = '0; req_a0 = '0; req_b0 = '0; req_sh0 = '0; req_tag0 = '0;
    req_opcode1 = '0; req_a1 = '0; req_b1 = '0; req_sh1 = '0; req_tag1 = '0;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_flags();
    test_reset_mid_op();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fu_scheduler.md
# fu_scheduler

Shares the single function unit between two requesters (decode lane 0 and decode lane 1) with round-robin arbitration and valid/ready handshakes on both sides. The block sits between the decode stages and the combinational function unit. It registers the chosen operation into the unit, captures the unit's result and flags one cycle later, and holds them in a response register until the consumer accepts them. The function unit is instantiated outside this block and connected through the fu_* ports.

## Interface
Parameters:
- TAGW, 5, width of the destination-register tag carried with each operation
- CNTW, 16, width of the completed-operation counter

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- req_valid[1:0]  in  2  per-requester operation valid
- req_ready[1:0]  out  2  per-requester accept; a transfer happens when valid and ready are both high
- req_opcode0 / req_opcode1  in  7 each  operation opcode (same encoding as the function unit)
- req_a0, req_b0 / req_a1, req_b1  in  32 each  operands
- req_sh0 / req_sh1  in  5 each  shift amount
- req_tag0 / req_tag1  in  TAGW each  destination tag
- fu_opcode  out  7  registered opcode to the function unit
- fu_a, fu_b  out  32 each  registered operands
- fu_sh  out  5  registered shift amount
- fu_fs  out  4  tied to 0
- fu_fout  in  32  function unit result
- fu_carryout, fu_overflow, fu_negative, fu_zero  in  1 each  function unit flags
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accept
- resp_id  out  1  index of the requester that issued the operation
- resp_tag  out  TAGW  tag of the operation
- resp_result  out  32  captured fu_fout
- resp_flags  out  4  captured {carryout, overflow, negative, zero}
- op_count  out  CNTW  number of completed response handshakes; wraps to 0 on overflow

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE**
  - Grant logic is combinational from req_valid and last_grant.
  - If exactly one requester is valid, that requester is granted.
  - If both are valid, the requester that is not last_grant is granted.
  - req_ready is high only for the granted requester; it is 0 for both requesters when neither is valid.
  - On a transfer: latch opcode, a, b, sh into the fu_* registers; latch tag and id; set last_grant to the granted index; go to EXEC.
- **EXEC**
  - req_ready is 0.
  - On the next edge: capture fu_fout into resp_result and the four flags into resp_flags; set resp_valid=1; go to DONE.
- **DONE**
  - req_ready is 0.
  - resp_* outputs are stable while resp_valid=1 and resp_ready=0.
  - When resp_ready=1: clear resp_valid, increment op_count, go to IDLE.
- The fu_* registers hold their last values outside EXEC. No new request is issued until the response is accepted.
- The block does not interpret opcodes; any 7-bit value is forwarded unchanged.
- **Reset** (asynchronous, valid in any state, including mid-operation): the in-flight operation is discarded and produces no response. After reset:
  - state=IDLE
  - last_grant=1, so requester 0 wins the first contention
  - resp_valid=0, resp_id=0, resp_tag=0, resp_result=0, resp_flags=0
  - op_count=0
  - fu_opcode, fu_a, fu_b, fu_sh = 0
  - req_ready follows the IDLE grant rule (0 while both req_valid are 0)

## Timing
- Accept on edge N (IDLE) → operands appear on fu_* after edge N → resp_valid=1 after edge N+1.
- Response handshake on edge M → block returns to IDLE after edge M. Earliest next accept is edge M+1.
- Best-case throughput: one operation per 3 cycles (resp_ready held high).
- req_ready depends combinationally on req_valid, the state and last_grant. It does not depend on req_ready or resp_ready.
- Requesters must hold valid and payload stable until accepted. A request that is not granted is not dropped; it keeps its place for the next IDLE.
- Simultaneous events:
  - A response handshake and a new req_valid in the same DONE cycle: the new request is not accepted in that cycle; it is accepted in the following IDLE cycle.
  - op_count at 2^CNTW−1 wraps to 0 on the next handshake.

## Test plan
- **Single ADD:** reset; req0 `ADD` with a=5, b=3, tag=7; resp_ready=1 → resp_valid 2 cycles after accept with resp_result=8, resp_id=0, resp_tag=7, resp_flags zero bit=0, op_count=1.
- **Contention:** both requesters valid continuously, 4 operations each → grant order 0,1,0,1,… with no starvation; resp_id alternates; one accept every 3 cycles.
- **Backpressure:** resp_ready=0 for 5 cycles after resp_valid → resp_* stable, req_ready=00 throughout; accepted on the 6th cycle, then op_count increments by exactly 1.
- **Flags:** req1 `SUB` with a=3, b=3 → resp_result=0, resp_flags zero bit=1, resp_id=1.
- **Reset mid-op:** assert rst during EXEC → resp_valid=0 immediately, no response emitted afterwards, op_count=0; the next request with both requesters valid grants requester 0.
- **Counter wrap:** preload the count via 2^CNTW−1 handshakes (CNTW=4 variant: 15 operations), run one more → op_count=0.
